// File: rtl/md_unit_pkg.sv
// md_unit_pkg: MD operation codes shared with the decoder and md_unit FSM state encodings
package md_unit_pkg;

    localparam logic [3:0] MD_mult  = 4'd0;
    localparam logic [3:0] MD_multu = 4'd1;
    localparam logic [3:0] MD_div   = 4'd2;
    localparam logic [3:0] MD_divu  = 4'd3;
    localparam logic [3:0] MD_mtlo  = 4'd4;
    localparam logic [3:0] MD_mthi  = 4'd5;
    localparam logic [3:0] MD_mflo  = 4'd6;
    localparam logic [3:0] MD_mfhi  = 4'd7;
    localparam logic [3:0] MD_none  = 4'b1111;

    localparam logic [0:0] MDS_IDLE = 1'b0;
    localparam logic [0:0] MDS_BUSY = 1'b1;

    // Multi-cycle operations occupy codes 0..3
    function automatic logic is_md(input logic [3:0] code);
        return code[3:2] == 2'b00;
    endfunction

endpackage

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit holding HI/LO with multi-cycle mult/div and single-cycle mt/mf
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MD_Control,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDout
);

    logic [0:0]  state;
    logic [3:0]  counter;
    logic [3:0]  op_l;
    logic [31:0] a_l, b_l;
    logic [31:0] ua, ub, den_s, den_u, q_s, r_s, q_u, r_u;
    logic [63:0] prod_s, prod_u;
    logic [31:0] hi_t, lo_t;
    logic        dz;

    // Result of the latched operation; signed divide works on magnitudes so INT_MIN/-1 and /0 never trap
    always_comb begin
        ua     = a_l[31] ? -a_l : a_l;
        ub     = b_l[31] ? -b_l : b_l;
        den_s  = (ub == 32'd0) ? 32'd1 : ub;
        den_u  = (b_l == 32'd0) ? 32'd1 : b_l;
        q_s    = ua / den_s;
        r_s    = ua % den_s;
        q_u    = a_l / den_u;
        r_u    = a_l % den_u;
        prod_s = {{32{a_l[31]}}, a_l} * {{32{b_l[31]}}, b_l};
        prod_u = {32'd0, a_l} * {32'd0, b_l};
        dz     = (op_l == MD_div || op_l == MD_divu) && b_l == 32'd0;
        {hi_t, lo_t} = (op_l == MD_mult)  ? prod_s :
                       (op_l == MD_multu) ? prod_u :
                       (op_l == MD_div)   ? {a_l[31] ? -r_s : r_s, (a_l[31] ^ b_l[31]) ? -q_s : q_s} :
                                            {r_u, q_u};
    end

    // FSM: latch operands on start, count down busy cycles, commit HI/LO on the last one; mt writes only when idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= MDS_IDLE;
            busy    <= 1'b0;
            counter <= 4'd0;
            op_l    <= 4'd0;
            a_l     <= 32'd0;
            b_l     <= 32'd0;
            HI      <= 32'd0;
            LO      <= 32'd0;
        end else if (state == MDS_IDLE) begin
            if (start && is_md(MD_Control)) begin
                state   <= MDS_BUSY;
                busy    <= 1'b1;
                op_l    <= MD_Control;
                a_l     <= A;
                b_l     <= B;
                counter <= MD_Control[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            end else if (MD_Control == MD_mthi) begin
                HI <= A;
            end else if (MD_Control == MD_mtlo) begin
                LO <= A;
            end
        end else if (counter == 4'd1) begin
            state   <= MDS_IDLE;
            busy    <= 1'b0;
            counter <= 4'd0;
            if (!dz) begin
                HI <= hi_t;
                LO <= lo_t;
            end
        end else begin
            counter <= counter - 4'd1;
        end
    end

    assign MDout = (MD_Control == MD_mfhi) ? HI : (MD_Control == MD_mflo) ? LO : 32'd0;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit
module tb_md_unit;
    import md_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  MD_Control = MD_none;
    logic        start = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy;
    logic [31:0] HI, LO, MDout;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cycles;

    md_unit dut (
        .clk(clk), .reset(reset), .MD_Control(MD_Control), .start(start),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO), .MDout(MDout)
    );

    always #5 clk = ~clk;

    // Issue one start pulse and count how many cycles busy stays high afterwards
    task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b, output int n);
        @(posedge clk); #1;
        MD_Control = code; start = 1'b1; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; MD_Control = MD_none;
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic mt_write(input logic [3:0] code, input logic [31:0] a);
        @(posedge clk); #1;
        MD_Control = code; A = a;
        @(posedge clk); #1;
        MD_Control = MD_none;
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_checks++; if (HI !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 0", HI); end
        n_checks++; if (LO !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 0", LO); end
        n_checks++; if (MDout !== 32'd0) begin n_fail++; $display("FAIL reset_mdout got %h want 0", MDout); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mult();
        run_op(MD_mult, 32'hFFFFFFFF, 32'd2, cycles);
        n_checks++; if (cycles != 5) begin n_fail++; $display("FAIL mult_cycles got %0d want 5", cycles); end
        n_checks++; if (HI !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi got %h want ffffffff", HI); end
        n_checks++; if (LO !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL mult_lo got %h want fffffffe", LO); end
        run_op(MD_multu, 32'hFFFFFFFF, 32'd2, cycles);
        n_checks++; if (cycles != 5) begin n_fail++; $display("FAIL multu_cycles got %0d want 5", cycles); end
        n_checks++; if (HI !== 32'h00000001) begin n_fail++; $display("FAIL multu_hi got %h want 00000001", HI); end
        n_checks++; if (LO !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_lo got %h want fffffffe", LO); end
    endtask

    task automatic test_div();
        run_op(MD_div, 32'hFFFFFFF9, 32'd2, cycles);
        n_checks++; if (cycles != 10) begin n_fail++; $display("FAIL div_cycles got %0d want 10", cycles); end
        n_checks++; if (LO !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_lo got %h want fffffffd", LO); end
        n_checks++; if (HI !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_hi got %h want ffffffff", HI); end
        run_op(MD_divu, 32'd7, 32'd2, cycles);
        n_checks++; if (cycles != 10) begin n_fail++; $display("FAIL divu_cycles got %0d want 10", cycles); end
        n_checks++; if (LO !== 32'd3) begin n_fail++; $display("FAIL divu_lo got %h want 3", LO); end
        n_checks++; if (HI !== 32'd1) begin n_fail++; $display("FAIL divu_hi got %h want 1", HI); end
    endtask

    task automatic test_mt_mf();
        @(posedge clk); #1;
        MD_Control = MD_mthi; A = 32'h12345678;
        @(posedge clk); #1;
        n_checks++; if (HI !== 32'h12345678) begin n_fail++; $display("FAIL mthi got %h want 12345678", HI); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy got %0b want 0", busy); end
        MD_Control = MD_mtlo; A = 32'h9ABCDEF0;
        @(posedge clk); #1;
        n_checks++; if (LO !== 32'h9ABCDEF0) begin n_fail++; $display("FAIL mtlo got %h want 9abcdef0", LO); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mtlo_busy got %0b want 0", busy); end
        MD_Control = MD_mfhi; A = 32'd0;
        #1;
        n_checks++; if (MDout !== 32'h12345678) begin n_fail++; $display("FAIL mfhi got %h want 12345678", MDout); end
        @(posedge clk); #1;
        MD_Control = MD_mflo;
        #1;
        n_checks++; if (MDout !== 32'h9ABCDEF0) begin n_fail++; $display("FAIL mflo got %h want 9abcdef0", MDout); end
        MD_Control = MD_none;
        #1;
        n_checks++; if (MDout !== 32'd0) begin n_fail++; $display("FAIL mdout_none got %h want 0", MDout); end
        n_checks++; if (HI !== 32'h12345678) begin n_fail++; $display("FAIL mf_no_write got %h want 12345678", HI); end
    endtask

    task automatic test_div_edge();
        mt_write(MD_mthi, 32'h11);
        mt_write(MD_mtlo, 32'h22);
        run_op(MD_div, 32'd100, 32'd0, cycles);
        n_checks++; if (cycles != 10) begin n_fail++; $display("FAIL divz_cycles got %0d want 10", cycles); end
        n_checks++; if (HI !== 32'h11) begin n_fail++; $display("FAIL divz_hi got %h want 11", HI); end
        n_checks++; if (LO !== 32'h22) begin n_fail++; $display("FAIL divz_lo got %h want 22", LO); end
        run_op(MD_divu, 32'd100, 32'd0, cycles);
        n_checks++; if (LO !== 32'h22) begin n_fail++; $display("FAIL divuz_lo got %h want 22", LO); end
        run_op(MD_div, 32'h80000000, 32'hFFFFFFFF, cycles);
        n_checks++; if (LO !== 32'h80000000) begin n_fail++; $display("FAIL divovf_lo got %h want 80000000", LO); end
        n_checks++; if (HI !== 32'd0) begin n_fail++; $display("FAIL divovf_hi got %h want 0", HI); end
    endtask

    task automatic test_reset_mid();
        mt_write(MD_mthi, 32'h5);
        mt_write(MD_mtlo, 32'h5);
        @(posedge clk); #1;
        MD_Control = MD_div; start = 1'b1; A = 32'd100; B = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; MD_Control = MD_none;
        repeat (3) begin @(posedge clk); #1; end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_prebusy got %0b want 1", busy); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %0b want 0", busy); end
        n_checks++; if (HI !== 32'd0) begin n_fail++; $display("FAIL midrst_hi got %h want 0", HI); end
        n_checks++; if (LO !== 32'd0) begin n_fail++; $display("FAIL midrst_lo got %h want 0", LO); end
        @(negedge clk);
        reset = 1'b0;
        run_op(MD_mult, 32'd3, 32'd4, cycles);
        n_checks++; if (cycles != 5) begin n_fail++; $display("FAIL postrst_cycles got %0d want 5", cycles); end
        n_checks++; if (LO !== 32'd12) begin n_fail++; $display("FAIL postrst_lo got %h want c", LO); end
        n_checks++; if (HI !== 32'd0) begin n_fail++; $display("FAIL postrst_hi got %h want 0", HI); end
    endtask

    task automatic test_ignore_busy();
        @(posedge clk); #1;
        MD_Control = MD_mult; start = 1'b1; A = 32'd6; B = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; MD_Control = MD_none;
        cycles = 0;
        while (busy && cycles < 40) begin
            if (cycles == 1) begin
                start = 1'b1; MD_Control = MD_multu; A = 32'd100; B = 32'd100;
            end else if (cycles == 2) begin
                start = 1'b0; MD_Control = MD_mthi; A = 32'hDEAD;
            end else begin
                start = 1'b0; MD_Control = MD_none;
            end
            cycles++;
            @(posedge clk); #1;
        end
        start = 1'b0; MD_Control = MD_none;
        n_checks++; if (cycles != 5) begin n_fail++; $display("FAIL ignbusy_cycles got %0d want 5", cycles); end
        n_checks++; if (LO !== 32'd42) begin n_fail++; $display("FAIL ignbusy_lo got %h want 2a", LO); end
        n_checks++; if (HI !== 32'd0) begin n_fail++; $display("FAIL ignbusy_hi got %h want 0", HI); end
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignbusy_idle got %0b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mt_mf();
        test_div_edge();
        test_reset_mid();
        test_ignore_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
